// File: rtl/mem_arbiter.sv
// N-master to 1-slave round-robin arbiter on the valid/ready memory protocol.
// The winning request is registered onto dn_*. The response is steered back to the granted master only.
module mem_arbiter #(
    parameter int N_MASTERS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          up_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   up_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   up_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   up_wstrb,
    output logic [N_MASTERS-1:0]          up_ready,
    output logic [DATA_W-1:0]             up_rdata,
    output logic [N_MASTERS-1:0]          up_err,
    output logic                          dn_valid,
    output logic [ADDR_W-1:0]             dn_addr,
    output logic [DATA_W-1:0]             dn_wdata,
    output logic [STRB_W-1:0]             dn_wstrb,
    input  logic                          dn_ready,
    input  logic [DATA_W-1:0]             dn_rdata
);

    localparam int GW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     rr_last;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     cand;
    logic              any_req;
    logic [WD_W-1:0]   wd;
    logic              timeout;
    logic              done;

    logic [ADDR_W-1:0] addr_a  [N_MASTERS];
    logic [DATA_W-1:0] wdata_a [N_MASTERS];
    logic [STRB_W-1:0] wstrb_a [N_MASTERS];

    always_comb begin
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            addr_a[i]  = up_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = up_wdata[i*DATA_W +: DATA_W];
            wstrb_a[i] = up_wstrb[i*STRB_W +: STRB_W];
        end
    end

    // Round-robin search starting just after the last winner, wrapping modulo N_MASTERS.
    always_comb begin
        grant   = rr_last;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = GW'((32'(rr_last) + k) % N_MASTERS);
            if (!any_req && up_valid[cand]) begin
                grant   = cand;
                any_req = 1'b1;
            end
        end
    end

    assign dn_valid = (state == BUSY);
    assign timeout  = (TIMEOUT_CYC > 0) && (state == BUSY) && (wd == WD_LAST) && !dn_ready;
    assign done     = (state == BUSY) && (dn_ready || timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // rr_last doubles as the index of the master owning the current BUSY transaction.
    always_comb begin
        state_nxt = state;
        up_ready  = '0;
        up_err    = '0;
        up_rdata  = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = BUSY;
            end
            BUSY: begin
                if (done) begin
                    state_nxt         = IDLE;
                    up_ready[rr_last] = 1'b1;
                    up_err[rr_last]   = timeout;
                    if (dn_ready) up_rdata = dn_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_addr  <= '0;
            dn_wdata <= '0;
            dn_wstrb <= '0;
            rr_last  <= GW'(N_MASTERS - 1);
            wd       <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                dn_addr  <= addr_a[grant];
                dn_wdata <= wdata_a[grant];
                dn_wstrb <= wstrb_a[grant];
                rr_last  <= grant;
            end
            wd <= '0;
        end else begin
            if (done)            wd <= '0;
            else if (wd != '1)   wd <= wd + 1'b1;
        end
    end

endmodule
